issue_scheduler: RTL and testbench

- Out-of-order issue queue controller with DEPTH renamed-op slots.
- Accepts ops from rename/dispatch and tracks per-operand readiness against the physical-register done flags.
- Each cycle, selects the oldest fully-ready op and issues it to one execution unit via valid/ready.
- Sits between the rename stage and a single functional-unit port; replaces a chain of single-entry buffers with age-ordered select.

---
 rtl/issue_scheduler.sv | 147 ++++++++++++++
 tb/tb_issue_scheduler.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/issue_scheduler.sv
// Age-ordered issue queue: holds renamed ops until all source operands are ready,
// then hands the oldest fully-ready op to a single execution port via valid/ready.
`ifndef RENAMED_OP_SZ
`define RENAMED_OP_SZ 28
`endif

module issue_scheduler #(
    parameter int INST_WIDTH = `RENAMED_OP_SZ,
    parameter int DEPTH      = 4,
    parameter int NUM_OPS    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [29:0]                  done_flags,
    input  logic                         flush,
    input  logic [INST_WIDTH-1:0]        in_instr,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [INST_WIDTH-1:0]        out_instr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [INST_WIDTH-1:0] data_q  [DEPTH];
    logic [INST_WIDTH-1:0] data_d  [DEPTH];
    logic [DEPTH-1:0]      older_q [DEPTH];
    logic [DEPTH-1:0]      older_d [DEPTH];
    logic [OCC_W-1:0]      occ_q, occ_d;

    logic [31:0]           done_ext;
    logic [NUM_OPS-1:0]    rdy      [DEPTH];
    logic [INST_WIDTH-1:0] merged   [DEPTH];
    logic [DEPTH-1:0]      elig;
    logic [DEPTH-1:0]      sel;
    logic [INST_WIDTH-1:0] sel_instr;
    logic [INST_WIDTH-1:0] in_merged;
    logic [IDX_W-1:0]      free_idx;
    logic                  issue_fire;
    logic                  alloc_fire;

    // Tags 0 and 1 are constants, so the two low positions of the extended
    // done vector are tied high and every tag indexes it directly.
    function automatic logic [NUM_OPS-1:0] ready_bits(input logic [INST_WIDTH-1:0] op,
                                                      input logic [31:0]           ext);
        logic [NUM_OPS-1:0] r;
        logic [4:0]         tag;
        r = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            tag  = op[8+5*i +: 5];
            r[i] = op[4+i] | ext[tag];
        end
        return r;
    endfunction

    function automatic logic [INST_WIDTH-1:0] merge_ready(input logic [INST_WIDTH-1:0] op,
                                                          input logic [NUM_OPS-1:0]    r);
        logic [INST_WIDTH-1:0] m;
        m              = op;
        m[4 +: NUM_OPS] = r;
        return m;
    endfunction

    // Wake-up, oldest-ready select and output mux.
    always_comb begin
        done_ext  = {done_flags, 2'b11};
        sel_instr = '0;
        elig      = '0;
        sel       = '0;
        for (int a = 0; a < DEPTH; a++) begin
            rdy[a]    = ready_bits(data_q[a], done_ext);
            merged[a] = merge_ready(data_q[a], rdy[a]);
            elig[a]   = valid_q[a] & (&rdy[a]);
        end
        for (int a = 0; a < DEPTH; a++) begin
            sel[a] = elig[a];
            for (int b = 0; b < DEPTH; b++) begin
                sel[a] = sel[a] & ~((b != a) & elig[b] & older_q[b][a]);
            end
            sel_instr = sel_instr | (sel[a] ? merged[a] : {INST_WIDTH{1'b0}});
        end
        out_valid = |elig;
        out_instr = out_valid ? sel_instr : merged[0];
    end

    // Allocation slot choice and handshake qualification.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            free_idx = !valid_q[i] ? IDX_W'(i) : free_idx;
        end
        in_ready   = (occ_q < OCC_W'(DEPTH)) & ~flush;
        alloc_fire = in_valid & in_ready;
        issue_fire = out_valid & out_ready & ~flush;
        in_merged  = merge_ready(in_instr, ready_bits(in_instr, done_ext));
    end

    // Next-state for slots, age matrix and occupancy.
    always_comb begin
        for (int a = 0; a < DEPTH; a++) begin
            logic alloc_here;
            alloc_here = alloc_fire & (free_idx == IDX_W'(a));
            valid_d[a] = alloc_here | (valid_q[a] & ~(issue_fire & sel[a]));
            data_d[a]  = alloc_here ? in_merged : (valid_q[a] ? merged[a] : data_q[a]);
            for (int b = 0; b < DEPTH; b++) begin
                // Every slot occupied before this edge becomes older than the new op.
                older_d[a][b] = (alloc_fire & (free_idx == IDX_W'(b))) ? valid_q[a]
                              : (alloc_here ? 1'b0 : older_q[a][b]);
            end
        end
        if (flush) begin
            valid_d = '0;
            occ_d   = '0;
            for (int a = 0; a < DEPTH; a++) begin
                older_d[a] = '0;
            end
        end else begin
            occ_d = occ_q + OCC_W'(alloc_fire) - OCC_W'(issue_fire);
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int a = 0; a < DEPTH; a++) begin
                data_q[a]  <= '0;
                older_q[a] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            for (int a = 0; a < DEPTH; a++) begin
                data_q[a]  <= data_d[a];
                older_q[a] <= older_d[a];
            end
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: expected issues are queued by the stimulus
// and popped by an independent monitor on each out_valid/out_ready handshake.
module tb_issue_scheduler;

    logic        clk;
    logic        rst;
    logic [29:0] done_flags;
    logic        flush;
    logic [27:0] in_instr;
    logic        in_valid;
    logic        in_ready;
    logic [27:0] out_instr;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  occupancy;

    int          n_tests;
    int          n_fail;
    logic [27:0] exp_q[$];

    issue_scheduler #(.INST_WIDTH(28), .DEPTH(4), .NUM_OPS(4)) dut (
        .clk(clk), .rst(rst), .done_flags(done_flags), .flush(flush),
        .in_instr(in_instr), .in_valid(in_valid), .in_ready(in_ready),
        .out_instr(out_instr), .out_valid(out_valid), .out_ready(out_ready),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [27:0] mk(input logic [4:0] t0, input logic [4:0] t1,
                                       input logic [4:0] t2, input logic [4:0] t3,
                                       input logic [3:0] r, input logic [3:0] id);
        return {t3, t2, t1, t0, r, id};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted issue must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_issue: got %h expected none", out_instr);
            end else begin
                check("issue_data", 32'(out_instr), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_instr   = 28'd0;
        out_ready  = 1'b0;
        done_flags = 30'd0;
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);

        // 1: op waits on tags 5,6; both wake in the same cycle.
        tick(); in_valid = 1'b1; in_instr = mk(5'd5, 5'd6, 5'd0, 5'd1, 4'h0, 4'd1);
        tick(); in_valid = 1'b0;
        @(negedge clk);
        check("t1_held_valid", 32'(out_valid), 32'd0);
        check("t1_occ", 32'(occupancy), 32'd1);
        tick(); done_flags = 30'h18;
        @(negedge clk);
        check("t1_wake_valid", 32'(out_valid), 32'd1);
        check("t1_wake_bits", 32'(out_instr[7:4]), 32'hF);
        check("t1_wake_instr", 32'(out_instr), 32'(mk(5'd5, 5'd6, 5'd0, 5'd1, 4'hF, 4'd1)));
        tick(); done_flags = 30'd0; out_ready = 1'b1;
        exp_q.push_back(mk(5'd5, 5'd6, 5'd0, 5'd1, 4'hF, 4'd1));
        tick(); out_ready = 1'b0;
        @(negedge clk);
        check("t1_empty_occ", 32'(occupancy), 32'd0);

        // 2: younger ready op bypasses older waiting op.
        tick(); in_valid = 1'b1; in_instr = mk(5'd9, 5'd0, 5'd0, 5'd0, 4'hE, 4'd2);
        tick(); in_instr = mk(5'd0, 5'd0, 5'd0, 5'd0, 4'hF, 4'd3);
        tick(); in_valid = 1'b0; out_ready = 1'b1;
        exp_q.push_back(mk(5'd0, 5'd0, 5'd0, 5'd0, 4'hF, 4'd3));
        tick();
        @(negedge clk);
        check("t2_a_waiting", 32'(out_valid), 32'd0);
        check("t2_occ", 32'(occupancy), 32'd1);
        tick(); done_flags = 30'h80;
        exp_q.push_back(mk(5'd9, 5'd0, 5'd0, 5'd0, 4'hF, 4'd2));
        tick(); done_flags = 30'd0; out_ready = 1'b0;
        @(negedge clk);
        check("t2_empty_occ", 32'(occupancy), 32'd0);

        // 3: one-cycle wake pulse with stalled port; sticky readiness, oldest first.
        tick(); in_valid = 1'b1; in_instr = mk(5'd12, 5'd0, 5'd0, 5'd0, 4'hE, 4'd4);
        tick(); in_instr = mk(5'd12, 5'd0, 5'd0, 5'd0, 4'hE, 4'd5);
        tick(); in_valid = 1'b0; done_flags = 30'h400;
        @(negedge clk);
        check("t3_oldest_sel", 32'(out_instr), 32'(mk(5'd12, 5'd0, 5'd0, 5'd0, 4'hF, 4'd4)));
        tick(); done_flags = 30'd0; out_ready = 1'b1;
        exp_q.push_back(mk(5'd12, 5'd0, 5'd0, 5'd0, 4'hF, 4'd4));
        exp_q.push_back(mk(5'd12, 5'd0, 5'd0, 5'd0, 4'hF, 4'd5));
        repeat (2) tick();
        out_ready = 1'b0;
        @(negedge clk);
        check("t3_empty_occ", 32'(occupancy), 32'd0);

        // 4: fill, issue one with in_valid held; new op must be youngest.
        tick(); in_valid = 1'b1; in_instr = mk(5'd0, 5'd0, 5'd0, 5'd0, 4'hF, 4'd6);
        for (int k = 7; k <= 9; k++) begin
            tick(); in_instr = mk(5'd20, 5'd0, 5'd0, 5'd0, 4'hE, 4'(k));
        end
        tick(); in_instr = mk(5'd20, 5'd0, 5'd0, 5'd0, 4'hE, 4'd10);
        @(negedge clk);
        check("t4_full_ready", 32'(in_ready), 32'd0);
        check("t4_full_occ", 32'(occupancy), 32'd4);
        tick(); out_ready = 1'b1;
        exp_q.push_back(mk(5'd0, 5'd0, 5'd0, 5'd0, 4'hF, 4'd6));
        @(negedge clk);
        check("t4_full_still", 32'(in_ready), 32'd0);
        tick(); out_ready = 1'b0;
        @(negedge clk);
        check("t4_freed_ready", 32'(in_ready), 32'd1);
        check("t4_freed_occ", 32'(occupancy), 32'd3);
        tick(); in_valid = 1'b0;
        @(negedge clk);
        check("t4_refill_occ", 32'(occupancy), 32'd4);
        tick(); done_flags = 30'h40000; out_ready = 1'b1;
        for (int k = 7; k <= 10; k++) begin
            exp_q.push_back(mk(5'd20, 5'd0, 5'd0, 5'd0, 4'hF, 4'(k)));
        end
        repeat (4) tick();
        done_flags = 30'd0; out_ready = 1'b0;
        @(negedge clk);
        check("t4_empty_occ", 32'(occupancy), 32'd0);

        // 5: flush drops queued ops plus the concurrent allocate and issue.
        tick(); in_valid = 1'b1; in_instr = mk(5'd0, 5'd0, 5'd0, 5'd0, 4'hF, 4'd11);
        tick(); in_instr = mk(5'd0, 5'd0, 5'd0, 5'd0, 4'hF, 4'd12);
        tick(); in_instr = mk(5'd0, 5'd0, 5'd0, 5'd0, 4'hF, 4'd13);
        tick(); in_instr = mk(5'd0, 5'd0, 5'd0, 5'd0, 4'hF, 4'd14);
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("t5_flush_in_ready", 32'(in_ready), 32'd0);
        check("t5_flush_out_valid", 32'(out_valid), 32'd1);
        tick(); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("t5_post_occ", 32'(occupancy), 32'd0);
        check("t5_post_valid", 32'(out_valid), 32'd0);

        // 6: back-to-back ready stream; one issue per cycle after fill.
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(mk(5'd1, 5'd0, 5'd1, 5'd0, 4'hF, 4'(k)));
        end
        for (int k = 0; k < 6; k++) begin
            tick(); in_valid = 1'b1; in_instr = mk(5'd1, 5'd0, 5'd1, 5'd0, 4'hF, 4'(k));
            @(negedge clk);
            if (k > 0) check("t6_stream_occ", 32'(occupancy), 32'd1);
        end
        tick(); in_valid = 1'b0;
        tick(); out_ready = 1'b0;
        @(negedge clk);
        check("t6_empty_occ", 32'(occupancy), 32'd0);

        repeat (2) tick();
        check("all_issued", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
